vector_dispatch: RTL

Parametrised front end for the vector (DFT4 + twiddle Hadamard) engine. It generalises the fixed four-lane, single-shot vector stage in four ways: LANES-wide operands, a DEPTH-entry request queue with valid/ready flow control, a per-request mode field plus a new engine-bypass path, and an engine watchdog. Requests are issued to the external engine strictly in order, one at a time, and its results are held in an output register until the consumer takes them.

---
 rtl/vector_dispatch.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/vector_dispatch.sv
// Request queue, in-order issue FSM and result register in front of the vector
// (DFT4 + twiddle Hadamard) engine, with an engine-bypass path and a hang watchdog.
//
// state | meaning
// IDLE  | waiting for a queued request; pops the head when one is present
// ISSUE | one-cycle eng_start pulse, watchdog loaded
// WAIT  | engine running; leaves on eng_done or watchdog expiry
// HOLD  | result presented on out_*, waiting for out_ready
module vector_dispatch #(
   parameter int formatWidth = 9,
   parameter int LANES       = 4,
   parameter int DEPTH       = 4,
   parameter int TIMEOUT     = 64
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [1:0]                     in_mode,
   input  logic                           in_bypass,
   input  logic [formatWidth*LANES-1:0]   in_real,
   input  logic [formatWidth*LANES-1:0]   in_imag,
   input  logic [formatWidth*LANES-1:0]   in_tw_real,
   input  logic [formatWidth*LANES-1:0]   in_tw_imag,
   output logic                           eng_start,
   output logic [1:0]                     eng_control,
   output logic [formatWidth*LANES-1:0]   eng_in_real,
   output logic [formatWidth*LANES-1:0]   eng_in_imag,
   output logic [formatWidth*LANES-1:0]   eng_tw_real,
   output logic [formatWidth*LANES-1:0]   eng_tw_imag,
   input  logic [formatWidth*LANES-1:0]   eng_out_real,
   input  logic [formatWidth*LANES-1:0]   eng_out_imag,
   input  logic                           eng_done,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [formatWidth*LANES-1:0]   out_real,
   output logic [formatWidth*LANES-1:0]   out_imag,
   output logic [2:0]                     out_tag,
   output logic                           busy,
   output logic [$clog2(DEPTH+1)-1:0]     level,
   output logic                           timeout_err
);

   localparam int VW = formatWidth * LANES;
   localparam int PW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH + 1);
   localparam int TW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

   state_t          state, state_nx;
   logic [VW-1:0]   q_real    [DEPTH];
   logic [VW-1:0]   q_imag    [DEPTH];
   logic [VW-1:0]   q_tw_real [DEPTH];
   logic [VW-1:0]   q_tw_imag [DEPTH];
   logic [1:0]      q_mode    [DEPTH];
   logic            q_bypass  [DEPTH];
   logic [PW-1:0]   wr_ptr, rd_ptr;
   logic [TW-1:0]   timer;
   logic            push, pop, expire;

   assign in_ready  = rst && (level < LW'(DEPTH));
   assign push      = in_valid && in_ready;
   assign pop       = (state == IDLE) && (level != '0);
   assign expire    = (timer == '0);
   assign eng_start = (state == ISSUE);
   assign out_valid = (state == HOLD);
   assign busy      = (state != IDLE) || (level != '0);

   always_ff @(posedge clk) begin
      if (push) begin
         q_real[wr_ptr]    <= in_real;
         q_imag[wr_ptr]    <= in_imag;
         q_tw_real[wr_ptr] <= in_tw_real;
         q_tw_imag[wr_ptr] <= in_tw_imag;
         q_mode[wr_ptr]    <= in_mode;
         q_bypass[wr_ptr]  <= in_bypass;
      end
   end

   // DEPTH is a power of two, so pointer overflow is the modulo wrap
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (pop) state_nx = q_bypass[rd_ptr] ? HOLD : ISSUE;
         ISSUE:   state_nx = WAIT;
         WAIT: begin
            if (eng_done)    state_nx = HOLD;
            else if (expire) state_nx = IDLE;
         end
         HOLD:    if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         timer       <= '0;
         timeout_err <= 1'b0;
         eng_control <= '0;
         eng_in_real <= '0;
         eng_in_imag <= '0;
         eng_tw_real <= '0;
         eng_tw_imag <= '0;
         out_real    <= '0;
         out_imag    <= '0;
         out_tag     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  if (q_bypass[rd_ptr]) begin
                     out_real <= q_real[rd_ptr];
                     out_imag <= q_imag[rd_ptr];
                     out_tag  <= {1'b1, q_mode[rd_ptr]};
                  end else begin
                     eng_control <= q_mode[rd_ptr];
                     eng_in_real <= q_real[rd_ptr];
                     eng_in_imag <= q_imag[rd_ptr];
                     eng_tw_real <= q_tw_real[rd_ptr];
                     eng_tw_imag <= q_tw_imag[rd_ptr];
                  end
               end
            end
            ISSUE: timer <= TW'(TIMEOUT - 1);
            // done is tested first so a completion on the expiry cycle is kept
            WAIT: begin
               if (eng_done) begin
                  out_real <= eng_out_real;
                  out_imag <= eng_out_imag;
                  out_tag  <= {1'b0, eng_control};
               end else if (expire) begin
                  timeout_err <= 1'b1;
               end else begin
                  timer <= timer - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
